// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
//   Issue controller for an external, purely combinational 8-bit ALU.
//   A command is accepted in IDLE and its operands and opcode are registered
//   onto alu_a/alu_b/alu_op. The controller spends one ISSUE cycle while the
//   ALU settles. It then captures alu_out into res_data and the accumulator,
//   and presents the result in DONE until the consumer takes it.
//   Peak throughput is one operation every three cycles.
//
//   Optional feature macro: ALU_CTRL_FLAGS_EN
//     When defined, the registered result flags res_zero and res_neg are
//     present. When undefined, those ports and their registers do not exist.
//
// Parameters
//   ACC_INIT     accumulator value loaded on reset
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous, active-high reset
//   cmd_valid    command present                (in)
//   cmd_ready    controller can accept, IDLE     (out)
//   cmd_op       opcode: add,sub,and,or,xor,not a,shl a,shr a (in)
//   cmd_a/cmd_b  operands                        (in)
//   cmd_use_acc  use accumulator as operand A    (in)
//   alu_a/alu_b  registered operands to the ALU  (out)
//   alu_op       registered opcode to the ALU    (out)
//   alu_out      combinational ALU result        (in)
//   res_valid    result available, DONE          (out)
//   res_ready    consumer accepts result         (in)
//   res_data     captured result                 (out)
//   acc          current accumulator             (out)
//   res_zero     res_data == 0   (ALU_CTRL_FLAGS_EN only)
//   res_neg      res_data[7]     (ALU_CTRL_FLAGS_EN only)
// -----------------------------------------------------------------------------
module alu_issue_ctrl #(
  parameter logic [7:0] ACC_INIT = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  input  logic       cmd_use_acc,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_op,
  input  logic [7:0] alu_out,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic [7:0] acc
`ifdef ALU_CTRL_FLAGS_EN
  ,
  output logic       res_zero,
  output logic       res_neg
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic       w_accept;
  logic       w_capture;

  logic [7:0] r_alu_a;
  logic [7:0] r_alu_b;
  logic [2:0] r_alu_op;
  logic [7:0] r_res_data;
  logic [7:0] r_acc;

  // Handshakes are only meaningful in their own state; everything else on
  // cmd_* and res_ready is ignored by construction.
  assign w_accept  = (r_state == S_IDLE) && cmd_valid;
  assign w_capture = (r_state == S_ISSUE);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment first guarantees every path drives
  // w_next_state, so no latch can be inferred.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:  if (cmd_valid) w_next_state = S_ISSUE;
      S_ISSUE: w_next_state = S_DONE;
      S_DONE:  if (res_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: these are a handful of control-visible registers, not a memory, so
  // every one is reset to a defined value; a reset mid-command discards it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_a    <= 8'h00;
      r_alu_b    <= 8'h00;
      r_alu_op   <= 3'b000;
      r_res_data <= 8'h00;
      r_acc      <= ACC_INIT;
    end else begin
      if (w_accept) begin
        // The accumulator seen here predates this command's own capture.
        r_alu_a  <= cmd_use_acc ? r_acc : cmd_a;
        r_alu_b  <= cmd_b;
        r_alu_op <= cmd_op;
      end
      // The ALU has had the whole ISSUE cycle to settle on the registered
      // operands, so alu_out is stable at this edge.
      if (w_capture) begin
        r_res_data <= alu_out;
        r_acc      <= alu_out;
      end
    end
  end

`ifdef ALU_CTRL_FLAGS_EN
  logic r_res_zero;
  logic r_res_neg;

  // Flags are taken from alu_out at the same edge as res_data rather than
  // decoded from res_data, so they stay aligned with it by construction.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_res_zero <= 1'b1;
      r_res_neg  <= 1'b0;
    end else if (w_capture) begin
      r_res_zero <= (alu_out == 8'h00);
      r_res_neg  <= alu_out[7];
    end
  end

  assign res_zero = r_res_zero;
  assign res_neg  = r_res_neg;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign cmd_ready = (r_state == S_IDLE);
  assign res_valid = (r_state == S_DONE);
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_op    = r_alu_op;
  assign res_data  = r_res_data;
  assign acc       = r_acc;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_ctrl
//   Directed bench for alu_issue_ctrl. The bench provides a behavioural model
//   of the downstream 8-bit ALU. Stimulus is driven on the falling edge, and
//   outputs are sampled on the falling edge before new inputs are applied.
//   Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_alu_issue_ctrl;

  localparam logic [7:0] ACC_INIT = 8'h5A;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic       cmd_use_acc;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_op;
  logic [7:0] alu_out;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic [7:0] acc;
`ifdef ALU_CTRL_FLAGS_EN
  logic       res_zero;
  logic       res_neg;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.ACC_INIT(ACC_INIT)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_use_acc(cmd_use_acc),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_out    (alu_out),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .acc        (acc)
`ifdef ALU_CTRL_FLAGS_EN
    ,
    .res_zero   (res_zero),
    .res_neg    (res_neg)
`endif
  );

  // Downstream combinational ALU.
  always_comb begin
    alu_out = 8'h00;
    case (alu_op)
      3'b000: alu_out = alu_a + alu_b;
      3'b001: alu_out = alu_a - alu_b;
      3'b010: alu_out = alu_a & alu_b;
      3'b011: alu_out = alu_a | alu_b;
      3'b100: alu_out = alu_a ^ alu_b;
      3'b101: alu_out = ~alu_a;
      3'b110: alu_out = alu_a << 1;
      3'b111: alu_out = alu_a >> 1;
      default: alu_out = 8'h00;
    endcase
  end

  task automatic check(input string tag, input logic [7:0] observed,
                       input logic [7:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic check_flags(input string tag, input logic exp_zero,
                             input logic exp_neg);
`ifdef ALU_CTRL_FLAGS_EN
    check({tag, ".res_zero"}, {7'd0, res_zero}, {7'd0, exp_zero});
    check({tag, ".res_neg"},  {7'd0, res_neg},  {7'd0, exp_neg});
`else
    // Flags are absent in this build; arguments intentionally unused.
    if (exp_zero === 1'bx && exp_neg === 1'bx && tag.len() < 0) total = total;
`endif
  endtask

  // Issue one command from IDLE and walk it through ISSUE and DONE. While the
  // command is in flight, a conflicting command is held on cmd_*, and it must
  // have no effect. DONE is held for n_hold falling-edge samples with
  // res_ready low before the result is accepted.
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic use_acc, input logic [7:0] exp_a,
                        input logic [7:0] exp_res, input logic exp_zero,
                        input logic exp_neg, input int n_hold);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = use_acc;
    @(negedge clk);                       // accepted at edge N -> ISSUE
    check({tag, ".issue.cmd_ready"}, {7'd0, cmd_ready}, 8'd0);
    check({tag, ".issue.res_valid"}, {7'd0, res_valid}, 8'd0);
    check({tag, ".alu_a"},  alu_a, exp_a);
    check({tag, ".alu_b"},  alu_b, b);
    check({tag, ".alu_op"}, {5'd0, alu_op}, {5'd0, op});
    // Conflicting command that must be ignored outside IDLE.
    cmd_op = ~op; cmd_a = 8'hEE; cmd_b = 8'hDD; cmd_use_acc = ~use_acc;
    for (int i = 0; i < n_hold; i++) begin
      @(negedge clk);                     // after edge N+1 -> DONE
      check({tag, ".done.res_valid"}, {7'd0, res_valid}, 8'd1);
      check({tag, ".done.cmd_ready"}, {7'd0, cmd_ready}, 8'd0);
      check({tag, ".res_data"}, res_data, exp_res);
      check({tag, ".acc"},      acc,      exp_res);
      check({tag, ".hold.alu_a"}, alu_a, exp_a);
      check_flags(tag, exp_zero, exp_neg);
    end
    res_ready = 1'b1;
    cmd_valid = 1'b0;
    @(negedge clk);                       // back in IDLE
    res_ready = 1'b0;
    check({tag, ".ret.cmd_ready"}, {7'd0, cmd_ready}, 8'd1);
    check({tag, ".ret.res_valid"}, {7'd0, res_valid}, 8'd0);
    check({tag, ".ret.res_data"},  res_data, exp_res);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b1; cmd_op = 3'b011; cmd_a = 8'h33;
    cmd_b = 8'h44; cmd_use_acc = 1'b0; res_ready = 1'b1;

    // Reset with a command presented at the same time: it must not be taken.
    @(negedge clk);
    @(negedge clk);
    check("rst.cmd_ready", {7'd0, cmd_ready}, 8'd1);
    check("rst.res_valid", {7'd0, res_valid}, 8'd0);
    check("rst.res_data",  res_data, 8'h00);
    check("rst.acc",       acc,      ACC_INIT);
    check("rst.alu_a",     alu_a,    8'h00);
    check("rst.alu_b",     alu_b,    8'h00);
    check("rst.alu_op",    {5'd0, alu_op}, 8'd0);
    check_flags("rst", 1'b1, 1'b0);
    rst = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0;

    // IDLE without a command: stays ready and the ALU registers hold.
    @(negedge clk);
    check("idle.cmd_ready", {7'd0, cmd_ready}, 8'd1);
    check("idle.alu_a",     alu_a, 8'h00);

    run_op("add0F01", 3'b000, 8'h0F, 8'h01, 1'b0, 8'h0F, 8'h10, 1'b0, 1'b0, 1);
    run_op("sub0505", 3'b001, 8'h05, 8'h05, 1'b0, 8'h05, 8'h00, 1'b1, 1'b0, 1);
    run_op("addFF02", 3'b000, 8'hFF, 8'h02, 1'b0, 8'hFF, 8'h01, 1'b0, 1'b0, 1);
    run_op("add1000", 3'b000, 8'h10, 8'h00, 1'b0, 8'h10, 8'h10, 1'b0, 1'b0, 1);
    run_op("shlacc",  3'b110, 8'hAA, 8'h00, 1'b1, 8'h10, 8'h20, 1'b0, 1'b0, 1);
    run_op("xorC3",   3'b100, 8'hC3, 8'hFF, 1'b0, 8'hC3, 8'h3C, 1'b0, 1'b0, 1);
    run_op("notacc",  3'b101, 8'h00, 8'h00, 1'b1, 8'h3C, 8'hC3, 1'b0, 1'b1, 1);
    // Backpressure: result 8'h80 held for five cycles with res_ready low.
    run_op("bp4040",  3'b000, 8'h40, 8'h40, 1'b0, 8'h40, 8'h80, 1'b0, 1'b1, 5);

    // Reset while in ISSUE: the command is discarded and never presented.
    cmd_valid = 1'b1; cmd_op = 3'b000; cmd_a = 8'h01; cmd_b = 8'h01;
    cmd_use_acc = 1'b0;
    @(negedge clk);
    check("rsti.in_issue", {7'd0, cmd_ready}, 8'd0);
    rst = 1'b1; cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rsti.cmd_ready", {7'd0, cmd_ready}, 8'd1);
    check("rsti.res_valid", {7'd0, res_valid}, 8'd0);
    check("rsti.acc",       acc,      ACC_INIT);
    check("rsti.res_data",  res_data, 8'h00);
    check_flags("rsti", 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rsti.never_valid", {7'd0, res_valid}, 8'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
